// File: rtl/karatsuba_68x86_tile_seq_if.sv
// karatsuba_68x86_tile_seq_if: operand/result handshakes and 34x43 core tile bus
// Ports (signals):
//   in_valid/in_ready/in_a/in_b     operand pair handshake (68 x 86 unsigned)
//   out_valid/out_ready/out_c       154-bit product handshake
//   core_a/core_b                   tile operands to the core
//   core_c                          core product, CORE_LAT cycles after core_a/core_b
//   busy                            operation in flight
// Modports: slave = sequencer side, master = environment side.
interface karatsuba_68x86_tile_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [67:0]  in_a;
    logic [85:0]  in_b;
    logic [33:0]  core_a;
    logic [42:0]  core_b;
    logic [76:0]  core_c;
    logic         out_valid;
    logic         out_ready;
    logic [153:0] out_c;
    logic         busy;

    modport slave (
        input  in_valid, in_a, in_b, core_c, out_ready,
        output in_ready, core_a, core_b, out_valid, out_c, busy
    );

    modport master (
        output in_valid, in_a, in_b, core_c, out_ready,
        input  in_ready, core_a, core_b, out_valid, out_c, busy
    );
endinterface

// File: rtl/karatsuba_68x86_tile_seq.sv
// karatsuba_68x86_tile_seq: 68x86 multiplier sequencing four 34x43 tiles through a pipelined core
// Ports:
//   clk  clock
//   rst  synchronous active-low reset
//   bus  slave side of karatsuba_68x86_tile_seq_if (operand in, core tile bus, result out, busy)
// Parameter CORE_LAT (1..8): core input-to-output latency in cycles.
module karatsuba_68x86_tile_seq #(
    parameter int CORE_LAT = 5
) (
    input logic clk,
    input logic rst,
    karatsuba_68x86_tile_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 k_q, k_d;
    logic [67:0]                a_q, a_d;
    logic [85:0]                b_q, b_d;
    logic [153:0]               acc_q, acc_d;
    logic [CORE_LAT-1:0]        tv_q, tv_d;
    logic [CORE_LAT-1:0][1:0]   tt_q, tt_d;
    logic                       hit;
    logic [1:0]                 tag;
    logic [6:0]                 off;

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        a_d = a_q;
        b_d = b_q;
        hit = tv_q[CORE_LAT-1];
        tag = tt_q[CORE_LAT-1];
        off = tag == 2'd0 ? 7'd0 : tag == 2'd1 ? 7'd34 : tag == 2'd2 ? 7'd43 : 7'd77;
        // last tag stage lines up with the core product of the tile issued CORE_LAT cycles ago
        acc_d = hit ? acc_q + ({77'd0, bus.core_c} << off) : acc_q;
        tv_d[0] = state_q == ISSUE;
        tt_d[0] = k_q;
        for (int i = 1; i < CORE_LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            tt_d[i] = tt_q[i-1];
        end
        // k[0] selects the A half, k[1] the B half: (A0,B0),(A1,B0),(A0,B1),(A1,B1)
        bus.core_a = state_q == ISSUE ? (k_q[0] ? a_q[67:34] : a_q[33:0]) : 34'd0;
        bus.core_b = state_q == ISSUE ? (k_q[1] ? b_q[85:43] : b_q[42:0]) : 43'd0;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d = bus.in_a;
                b_d = bus.in_b;
                acc_d = '0;
                k_d = 2'd0;
                state_d = ISSUE;
            end
            ISSUE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = DRAIN;
            end
            DRAIN: if (hit && tag == 2'd3) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        bus.in_ready = state_q == IDLE;
        bus.busy = state_q != IDLE;
        bus.out_valid = state_q == DONE;
        bus.out_c = acc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q <= '0;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            tv_q <= '0;
            tt_q <= '0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            tv_q <= tv_d;
            tt_q <= tt_d;
        end
    end
endmodule
